// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions for the width-converter family.
// Contents:
//   AXIS_WIDE_W / AXIS_NARROW_W - default wide and narrow data widths
//   axis_wide_t / axis_narrow_t - packed beat structs (data, keep, last)
//   axis_wd_state_e             - down-converter state {EMPTY, DRAIN}
package axis_pkg;

  localparam int AXIS_WIDE_W   = 512;
  localparam int AXIS_NARROW_W = 64;

  typedef struct packed {
    logic [AXIS_WIDE_W-1:0]   data;
    logic [AXIS_WIDE_W/8-1:0] keep;
    logic                     last;
  } axis_wide_t;

  typedef struct packed {
    logic [AXIS_NARROW_W-1:0]   data;
    logic [AXIS_NARROW_W/8-1:0] keep;
    logic                       last;
  } axis_narrow_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } axis_wd_state_e;

endpackage

// File: rtl/axis_keep_top_lane.sv
// Combinational priority encoder over a wide tkeep bus.
// Ports:
//   keep_i     - wide byte qualifiers, split into RATIO equal lanes
//   top_o      - index of the highest lane holding any set keep bit (0 if none)
//   all_zero_o - 1 when no keep bit is set at all
module axis_keep_top_lane #(
  parameter int KEEP_W = 64,
  parameter int RATIO  = 8,
  parameter int LANE_W = 3
) (
  input  logic [KEEP_W-1:0] keep_i,
  output logic [LANE_W-1:0] top_o,
  output logic              all_zero_o
);

  localparam int LANE_KEEP_W = KEEP_W / RATIO;

  // Ascending scan: the last hit wins, giving the highest non-null lane.
  always_comb begin
    top_o      = '0;
    all_zero_o = 1'b1;
    for (int i = 0; i < RATIO; i++) begin
      if (|keep_i[i*LANE_KEEP_W +: LANE_KEEP_W]) begin
        top_o      = LANE_W'(i);
        all_zero_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axis_width_down.sv
// AXI-Stream down-converter: accepts one wide beat into a holding register and
// replays it as narrow beats, lane 0 first, stopping after the highest lane
// that carries any keep bit. Zero-bubble reload when the last lane hands off.
// Ports:
//   s_aclk, s_aresetn           - clock, async active-low reset
//   s_axis_t{data,keep,last}    - wide beat in; s_axis_tvalid/tready handshake
//   m_axis_t{data,keep,last}    - narrow beat out; m_axis_tvalid/tready handshake
// Handshake: a transfer happens on a rising edge where valid && ready; the
// source holds its beat stable until then. s_axis_tready never depends on
// s_axis_tvalid; m_axis_* hold stable while valid && !ready.
module axis_width_down
  import axis_pkg::*;
#(
  parameter int S_TDATA_WIDTH = AXIS_WIDE_W,
  parameter int M_TDATA_WIDTH = AXIS_NARROW_W
) (
  input  logic                       s_aclk,
  input  logic                       s_aresetn,
  input  logic [S_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                       s_axis_tlast,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [M_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready
);

  localparam int RATIO  = S_TDATA_WIDTH / M_TDATA_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int S_KW   = S_TDATA_WIDTH / 8;
  localparam int M_KW   = M_TDATA_WIDTH / 8;

  axis_wd_state_e           state_q;
  logic [S_TDATA_WIDTH-1:0] data_q;
  logic [S_KW-1:0]          keep_q;
  logic                     last_q;
  logic [LANE_W-1:0]        lane_q;
  logic [LANE_W-1:0]        top_q;
  // Held low through reset so the upstream FIFO sees tready=0 until the
  // first clock after release.
  logic                     rdy_q;

  logic [LANE_W-1:0] top_w;
  logic              all_zero_w;
  logic              m_hs;
  logic              beat_done;
  logic              accept;

  axis_keep_top_lane #(
    .KEEP_W (S_KW),
    .RATIO  (RATIO),
    .LANE_W (LANE_W)
  ) u_top_lane (
    .keep_i     (s_axis_tkeep),
    .top_o      (top_w),
    .all_zero_o (all_zero_w)
  );

  assign m_hs          = (state_q == DRAIN) && m_axis_tready;
  assign beat_done     = m_hs && (lane_q == top_q);
  assign s_axis_tready = rdy_q && ((state_q == EMPTY) || beat_done);
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state_q <= EMPTY;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      lane_q  <= '0;
      top_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (accept) begin
        // A keep-less non-last beat carries nothing worth emitting.
        if (all_zero_w && !s_axis_tlast) begin
          state_q <= EMPTY;
        end else begin
          state_q <= DRAIN;
          data_q  <= s_axis_tdata;
          keep_q  <= s_axis_tkeep;
          last_q  <= s_axis_tlast;
          lane_q  <= '0;
          top_q   <= top_w;
        end
      end else if (beat_done) begin
        state_q <= EMPTY;
      end else if (m_hs) begin
        lane_q <= lane_q + LANE_W'(1);
      end
    end
  end

  always_comb begin
    m_axis_tvalid = (state_q == DRAIN);
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    if (state_q == DRAIN) begin
      m_axis_tdata = data_q[lane_q*M_TDATA_WIDTH +: M_TDATA_WIDTH];
      m_axis_tkeep = keep_q[lane_q*M_KW +: M_KW];
      m_axis_tlast = last_q && (lane_q == top_q);
    end
  end

endmodule

// File: tb/tb_axis_width_down.sv
// Randomized bench for axis_width_down with a lane-list reference model.
module tb_axis_width_down;
  import axis_pkg::*;

  localparam int S_W = 512;
  localparam int M_W = 64;
  localparam int EW  = 1 + 1 + 8 + 64; // {final_lane, last, keep, data}

  logic             clk;
  logic             rst_n;
  logic [S_W-1:0]   s_axis_tdata;
  logic [S_W/8-1:0] s_axis_tkeep;
  logic             s_axis_tlast;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic [M_W-1:0]   m_axis_tdata;
  logic [M_W/8-1:0] m_axis_tkeep;
  logic             m_axis_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready;

  axis_width_down #(
    .S_TDATA_WIDTH (S_W),
    .M_TDATA_WIDTH (M_W)
  ) dut (
    .s_aclk        (clk),
    .s_aresetn     (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit, required end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int             n_checks = 0;
  int             n_errors = 0;
  logic [EW-1:0]  exp_q[$];
  axis_wide_t     src_q[$];
  int             hs_count;
  int             val_count;
  int             vfirst;
  int             vlast;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  // Reference model: a wide beat becomes lanes 0..top, where top is the
  // highest lane with any keep bit; keep-less beats collapse to one marker
  // beat when they close a packet and vanish otherwise.
  task automatic model_push(input axis_wide_t b, output bit prod);
    int top;
    top  = -1;
    prod = 1'b0;
    for (int i = 0; i < 8; i++)
      if (b.keep[i*8 +: 8] != 8'h00) top = i;
    if (top < 0) begin
      if (b.last) begin
        exp_q.push_back({1'b1, 1'b1, 8'h00, b.data[63:0]});
        prod = 1'b1;
      end
    end else begin
      for (int i = 0; i <= top; i++)
        exp_q.push_back({(i == top), (b.last && i == top), b.keep[i*8 +: 8], b.data[i*64 +: 64]});
      prod = 1'b1;
    end
  endtask

  function automatic axis_wide_t gen_beat(input int kmode, input bit last);
    axis_wide_t b;
    int n;
    for (int i = 0; i < 16; i++) b.data[i*32 +: 32] = $urandom();
    b.last = last;
    case (kmode)
      0: b.keep = '1;
      1: b.keep = '0;
      2: begin
        n = $urandom_range(1, 63);
        b.keep = (64'd1 << n) - 64'd1;
      end
      default: begin
        b.keep = {$urandom(), $urandom()};
        for (int i = 0; i < 8; i++)
          if ($urandom_range(0, 2) == 0) b.keep[i*8 +: 8] = 8'h00;
      end
    endcase
    return b;
  endfunction

  // ---------------- driver / monitor ----------------
  task automatic run(input bit rand_ready, input bit rand_gap, input int budget);
    axis_wide_t     cur;
    bit             cur_valid;
    bit             done;
    bit             lat_pending;
    bit             stall_prev;
    bit             prod;
    bit             exp_rdy;
    logic [72:0]    held;
    cur_valid   = 1'b0;
    done        = 1'b0;
    lat_pending = 1'b0;
    stall_prev  = 1'b0;
    held        = '0;
    cur         = '0;
    hs_count    = 0;
    val_count   = 0;
    vfirst      = -1;
    vlast       = -1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(posedge clk); #1;
      if (!cur_valid && src_q.size() > 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
        cur       = src_q.pop_front();
        cur_valid = 1'b1;
      end
      s_axis_tvalid = cur_valid;
      s_axis_tdata  = cur.data;
      s_axis_tkeep  = cur.keep;
      s_axis_tlast  = cur.last;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (stall_prev)
        check("stall_stable", {1'b1, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
              {1'b1, 1'b1, held});
      if (lat_pending) check("latency_valid", m_axis_tvalid, 1'b1);
      lat_pending = 1'b0;
      exp_rdy = !m_axis_tvalid ||
                (m_axis_tready && exp_q.size() > 0 && exp_q[0][EW-1]);
      check("s_tready", s_axis_tready, exp_rdy);
      if (m_axis_tvalid) begin
        val_count++;
        if (vfirst < 0) vfirst = cyc;
        vlast = cyc;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
        end else begin
          check("narrow_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q[0][72:0]);
          void'(exp_q.pop_front());
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held       = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (s_axis_tvalid && s_axis_tready) begin
        model_push(cur, prod);
        lat_pending = prod;
        cur_valid   = 1'b0;
      end
      if (!cur_valid && src_q.size() == 0 && exp_q.size() == 0 &&
          !m_axis_tvalid && !lat_pending) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", done, 1'b1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    axis_wide_t b;
    int total;
    rst_n         = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, '0);
    check("rst_tready", s_axis_tready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_before_clock", s_axis_tready, 1'b0);
    @(negedge clk);
    check("tready_after_release", s_axis_tready, 1'b1);

    // Full beat
    src_q.push_back(gen_beat(0, 1'b1));
    run(1'b0, 1'b0, 100);
    check("full_count", hs_count, 8);

    // Partial last beat: 8 + 2 lanes
    src_q.push_back(gen_beat(0, 1'b0));
    b = gen_beat(0, 1'b1);
    b.keep = 64'h0000_0000_0000_0FFF;
    src_q.push_back(b);
    run(1'b0, 1'b0, 100);
    check("partial_count", hs_count, 10);

    // Zero bubble: three full beats back to back
    src_q.push_back(gen_beat(0, 1'b0));
    src_q.push_back(gen_beat(0, 1'b0));
    src_q.push_back(gen_beat(0, 1'b1));
    run(1'b0, 1'b0, 100);
    check("bubble_valid_cycles", val_count, 24);
    check("bubble_span", vlast - vfirst + 1, 24);

    // Zero keep, last and non-last
    src_q.push_back(gen_beat(1, 1'b1));
    run(1'b0, 1'b0, 50);
    check("zero_keep_last_count", hs_count, 1);
    src_q.push_back(gen_beat(1, 1'b0));
    run(1'b0, 1'b0, 50);
    check("zero_keep_nonlast_count", hs_count, 0);

    // Backpressure and random packets
    total = 0;
    for (int p = 0; p < 8; p++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++)
        src_q.push_back(gen_beat((k == nb - 1) ? $urandom_range(0, 3) : $urandom_range(0, 1) * 3,
                                 (k == nb - 1)));
    end
    run(1'b1, 1'b1, 2000);
    for (int p = 0; p < 40; p++)
      src_q.push_back(gen_beat($urandom_range(0, 3), 1'($urandom_range(0, 1))));
    run(1'b1, 1'b1, 4000);
    for (int p = 0; p < 20; p++)
      src_q.push_back(gen_beat($urandom_range(0, 3), 1'($urandom_range(0, 1))));
    run(1'b0, 1'b0, 2000);

    // Mid-operation reset at lane 3
    b = gen_beat(0, 1'b1);
    @(posedge clk); #1;
    s_axis_tdata  = b.data;
    s_axis_tkeep  = b.keep;
    s_axis_tlast  = b.last;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("mid_accept_tready", s_axis_tready, 1'b1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_lane3", {m_axis_tvalid, m_axis_tdata}, {1'b1, b.data[192 +: 64]});
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, '0);
    check("mid_rst_tready", s_axis_tready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    b = gen_beat(2, 1'b1);
    src_q.push_back(b);
    total = 0;
    for (int i = 0; i < 8; i++)
      if (b.keep[i*8 +: 8] != 8'h00) total = i + 1;
    run(1'b0, 1'b0, 100);
    check("post_reset_count", hs_count, total);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
